// File: rtl/sat_narrow.sv
// sat_narrow: rounds and rescales a wide signed value, then saturates or wraps it to SIZE_OUT bits.
// Two-stage valid/ready pipeline with sticky overflow flag and saturation event counter.
module sat_narrow #(
    parameter int SIZE_IN  = 32,
    parameter int SIZE_OUT = 16,
    parameter int SHIFT_W  = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE_IN-1:0]  valin,
    input  logic [SHIFT_W-1:0]  shamt,
    input  logic                sat_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE_OUT-1:0] reduced,
    output logic                ovf,
    output logic                ovf_sticky,
    output logic [CNT_W-1:0]    sat_count,
    input  logic                clr_stats
);
    logic                        advance, s1_valid, s1_sat, ovf_n, rbit;
    logic signed [SIZE_IN:0]     ext, shifted, s1_val;
    logic [SIZE_IN-SIZE_OUT+1:0] hi;
    logic [SIZE_OUT-1:0]         narrow;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        ext     = {valin[SIZE_IN-1], valin};
        shifted = ext >>> shamt;
        rbit    = shamt != '0 ? valin[shamt - 1'b1] : 1'b0;
        // value fits only when every bit from the output sign bit upward is identical
        hi      = s1_val[SIZE_IN:SIZE_OUT-1];
        ovf_n   = !(&hi || ~|hi);
        narrow  = ovf_n && s1_sat ? {s1_val[SIZE_IN], {(SIZE_OUT-1){~s1_val[SIZE_IN]}}}
                                  : s1_val[SIZE_OUT-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
            s1_sat   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_val   <= shifted + {{SIZE_IN{1'b0}}, rbit};
            s1_sat   <= sat_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            reduced   <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            reduced   <= narrow;
            ovf       <= ovf_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (clr_stats) begin
            ovf_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (s1_valid && advance && ovf_n) begin
            ovf_sticky <= 1'b1;
            if (s1_sat && !(&sat_count))
                sat_count <= sat_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sat_narrow.sv
// tb_sat_narrow: randomized scoreboard bench for sat_narrow against an arithmetic reference model.
module tb_sat_narrow;
    localparam int CW = 4;
    logic clk = 0, rst = 1, in_valid = 0, sat_en = 0, out_ready = 1, clr_stats = 0;
    logic in_ready, out_valid, ovf, ovf_sticky;
    logic [31:0] valin = 0;
    logic [4:0] shamt = 0;
    logic [15:0] reduced;
    logic [CW-1:0] sat_count;
    int checks = 0, errors = 0;
    bit rnd = 0, seen = 0;
    logic exp_sticky = 0;
    int exp_cnt = 0;

    typedef struct {logic [15:0] red; logic ovf; logic sat; logic clr;} exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    sat_narrow #(.SIZE_IN(32), .SIZE_OUT(16), .SHIFT_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .valin(valin),
        .shamt(shamt), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
        .reduced(reduced), .ovf(ovf), .ovf_sticky(ovf_sticky), .sat_count(sat_count),
        .clr_stats(clr_stats));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // round-half-up rescale is floor((x + 2^(s-1)) / 2^s) in exact integer arithmetic
    function automatic exp_t model(input logic [31:0] v, input logic [4:0] s, input logic sat);
        exp_t r;
        longint x, y;
        x = longint'($signed(v));
        y = (s == 0) ? x : (x + (longint'(1) << (s - 1))) >>> s;
        r.ovf = (y > 32767) || (y < -32768);
        r.red = (r.ovf && sat) ? ((y > 0) ? 16'h7FFF : 16'h8000) : y[15:0];
        r.sat = sat;
        r.clr = 0;
        return r;
    endfunction

    task automatic send(input logic [31:0] v, input logic [4:0] s, input logic sat);
        in_valid = 1; valin = v; shamt = s; sat_en = sat;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(model(v, s, sat));
                @(posedge clk);
                #1 in_valid = 0;
                return;
            end
        end
        chk("send_timeout", {31'b0, in_ready}, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        #1 chk("drain", q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        #1 if (rnd) out_ready = $urandom_range(0, 3) != 0;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete(); seen = 0; exp_sticky = 0; exp_cnt = 0;
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_beat", {31'b0, out_valid}, 0);
                else begin
                    e = q[0];
                    if (!seen) begin
                        seen = 1;
                        if (e.clr) begin exp_sticky = 0; exp_cnt = 0; end
                        else if (e.ovf) begin
                            exp_sticky = 1;
                            if (e.sat && exp_cnt < (1 << CW) - 1) exp_cnt++;
                        end
                    end
                    chk("reduced", {16'b0, reduced}, {16'b0, e.red});
                    chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                    chk("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, exp_sticky});
                    chk("sat_count", 32'(sat_count), exp_cnt);
                    if (out_ready) begin void'(q.pop_front()); seen = 0; end
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_reduced", {16'b0, reduced}, 0);
        chk("rst_ovf", {31'b0, ovf}, 0);
        chk("rst_sticky", {31'b0, ovf_sticky}, 0);
        chk("rst_sat_count", 32'(sat_count), 0);
        rst = 0;
        #1 chk("rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        send(32'h00001234, 0, 1);
        send(32'h00012345, 0, 1);
        send(32'h00012345, 0, 0);
        send(32'hFFFF8000, 0, 1);
        send(32'hFFFF0000, 0, 1);
        send(32'h00000003, 1, 1);
        send(32'hFFFFFFFD, 1, 1);
        send(32'h7FFFFFFF, 16, 1);
        drain();
        fork
            for (int i = 1; i <= 4; i++) send(i, 0, 1);
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        send(32'h00400000, 0, 1);
        q[$].clr = 1;
        clr_stats = 1;
        @(posedge clk);
        #1 clr_stats = 0;
        drain();
        chk("clr_sticky", {31'b0, ovf_sticky}, 0);
        chk("clr_sat_count", 32'(sat_count), 0);
        repeat (20) send(32'h40000000, 0, 1);
        send(32'hC0000000, 0, 0);
        drain();
        chk("cnt_saturated", 32'(sat_count), (1 << CW) - 1);
        send(32'h5, 0, 1);
        send(32'h6, 0, 1);
        #1 rst = 1;
        #1 chk("async_rst_out_valid", {31'b0, out_valid}, 0);
        chk("async_rst_sat_count", 32'(sat_count), 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 0;
        repeat (4) @(posedge clk);
        #1 chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        rnd = 1;
        repeat (300) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 131071)) - 32'd65536;
                2: v = 32'h00007FFE + 32'($urandom_range(0, 3));
                default: v = 32'hFFFF7FFE + 32'($urandom_range(0, 3));
            endcase
            send(v, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd = 0;
        @(posedge clk);
        #2 out_ready = 1;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
